// File: rtl/rf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : rf_ctrl_pkg
// Brief  : Shared constants and pipe-stage layout for the register-file
//          hazard / write-back scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package rf_ctrl_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int NUM_REGS      = 32;
  localparam int SHORT_LAT_DEF = 3;

  // Encoding of the decode pause vector {pause_rt, pause_rs}
  localparam logic [1:0] PAUSE_NO   = 2'b00;
  localparam logic [1:0] PAUSE_RS   = 2'b01;
  localparam logic [1:0] PAUSE_RT   = 2'b10;
  localparam logic [1:0] PAUSE_BOTH = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
  } pipe_stage_t;

endpackage : rf_ctrl_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : rf_scoreboard
// Brief  : Per-register pending-write bits with one set port, one clear port
//          and three combinational lookups (rs, rt, dest).
// Rev    : 1.0  initial release
// ============================================================================
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] dest_addr,
  output logic                  rs_pend,
  output logic                  rt_pend,
  output logic                  dest_pend
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;

  // $0 is hard-wired, so its bit can never become pending
  assign w_set_mask = (set_en && set_addr != '0) ? (NUM_REGS'(1) << set_addr) : '0;
  assign w_clr_mask = clr_en ? (NUM_REGS'(1) << clr_addr) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

  assign rs_pend   = r_pending[rs_addr];
  assign rt_pend   = r_pending[rt_addr];
  assign dest_pend = r_pending[dest_addr];

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module : rf_wb_scheduler
// Brief  : Decode hazard detection and single-write-port arbitration between
//          the fixed-latency short pipe and one multi-cycle long unit.
// Rev    : 1.0  initial release
// ============================================================================
module rf_wb_scheduler
  import rf_ctrl_pkg::*;
#(
  parameter int SHORT_LAT = SHORT_LAT_DEF,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rt_used,
  input  logic              id_wen,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_long,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_done,
  input  logic [DATA_W-1:0] lu_data,
  output logic [1:0]        pause,
  output logic              issue,
  output logic              lu_start,
  output logic              lu_busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  logic              w_rs_pend;
  logic              w_rt_pend;
  logic              w_dest_pend;
  logic [1:0]        w_pause;
  logic              w_struct_stall;
  logic              w_issue;
  logic              w_short_we;
  logic              w_lu_done;
  logic              w_long_commit;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_rf_we;

  pipe_stage_t       r_pipe [SHORT_LAT];
  logic              r_lu_busy;
  logic [ADDR_W-1:0] r_lu_dest;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_data;

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (w_issue && id_wen),
    .set_addr  (id_dest),
    .clr_en    (w_rf_we),
    .clr_addr  (w_waddr),
    .rs_addr   (id_rs),
    .rt_addr   (id_rt),
    .dest_addr (id_dest),
    .rs_pend   (w_rs_pend),
    .rt_pend   (w_rt_pend),
    .dest_pend (w_dest_pend)
  );

  always_comb begin
    w_pause = PAUSE_NO;
    if (id_valid && !rst) begin
      w_pause[0] = (id_rs != '0) && w_rs_pend;
      w_pause[1] = id_rt_used && (id_rt != '0) && w_rt_pend;
    end
  end

  // The hold register only blocks short issue: a new long op is already
  // blocked by lu_busy, which stays high until the held result commits.
  assign w_struct_stall = (id_wen && w_dest_pend) ||
                          (id_long && r_lu_busy) ||
                          (r_hold_full && !id_long);
  assign w_issue = id_valid && !rst && (w_pause == PAUSE_NO) && !w_struct_stall;

  // A done pulse with nothing outstanding (e.g. after reset) is ignored
  assign w_lu_done  = lu_done && r_lu_busy && !r_hold_full;
  assign w_short_we = r_pipe[SHORT_LAT-1].valid;

  always_comb begin
    w_we          = 1'b0;
    w_waddr       = '0;
    w_wdata       = '0;
    w_long_commit = 1'b0;
    if (w_short_we) begin
      w_we    = 1'b1;
      w_waddr = r_pipe[SHORT_LAT-1].dest;
      w_wdata = wb_data;
    end else if (r_hold_full) begin
      w_we          = 1'b1;
      w_waddr       = r_lu_dest;
      w_wdata       = r_hold_data;
      w_long_commit = 1'b1;
    end else if (w_lu_done) begin
      w_we          = 1'b1;
      w_waddr       = r_lu_dest;
      w_wdata       = lu_data;
      w_long_commit = 1'b1;
    end
  end

  assign w_rf_we = w_we && (w_waddr != '0) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SHORT_LAT; i++) begin
        r_pipe[i] <= '0;
      end
      r_lu_busy   <= 1'b0;
      r_lu_dest   <= '0;
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else begin
      // Writers to $0 and non-writers never occupy the write port
      r_pipe[0].valid <= w_issue && !id_long && id_wen && (id_dest != '0);
      r_pipe[0].dest  <= id_dest;
      for (int i = 1; i < SHORT_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end

      if (w_issue && id_long) begin
        r_lu_busy <= 1'b1;
        r_lu_dest <= id_wen ? id_dest : '0;
      end else if (w_long_commit) begin
        r_lu_busy <= 1'b0;
      end

      if (w_lu_done && w_short_we) begin
        r_hold_full <= 1'b1;
        r_hold_data <= lu_data;
      end else if (r_hold_full && !w_short_we) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign pause    = w_pause;
  assign issue    = w_issue;
  assign lu_start = w_issue && id_long;
  assign lu_busy  = r_lu_busy;
  assign rf_we    = w_rf_we;
  assign rf_waddr = w_waddr;
  assign rf_wdata = w_wdata;

endmodule : rf_wb_scheduler
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_rf_wb_scheduler
// Brief  : Directed plus randomized bench for rf_wb_scheduler, checked every
//          cycle against a queue-based behavioural model of the scheduler.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rf_wb_scheduler;

  localparam int SHORT_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_rt_used = 1'b0;
  logic        id_wen = 1'b0;
  logic [4:0]  id_dest = '0;
  logic        id_long = 1'b0;
  logic [31:0] wb_data = '0;
  logic        lu_done = 1'b0;
  logic [31:0] lu_data = '0;
  logic [1:0]  pause;
  logic        issue;
  logic        lu_start;
  logic        lu_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  rf_wb_scheduler #(.SHORT_LAT(SHORT_LAT), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rt_used(id_rt_used), .id_wen(id_wen), .id_dest(id_dest), .id_long(id_long),
    .wb_data(wb_data), .lu_done(lu_done), .lu_data(lu_data), .pause(pause),
    .issue(issue), .lu_start(lu_start), .lu_busy(lu_busy), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: pending set, queue of scheduled short writes, long op state
  typedef struct { int due; logic [4:0] dest; } sw_t;
  bit          pend [32];
  sw_t         sq [$];
  bit          m_out, m_held;
  logic [4:0]  m_ldest;
  logic [31:0] m_hdata;
  int          cyc = 0;
  int          cnt = 0;
  int          next_lat = 3;
  logic [31:0] next_data = '0;
  logic [31:0] cur_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [4:0] rs, input logic [4:0] rt,
                      input bit used, input bit wen, input logic [4:0] d, input bit lng,
                      input bit extra_done);
    bit          sw_now, s_stall, e_issue, e_we, was_held, done_ok;
    logic [1:0]  e_pause;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    @(negedge clk);
    rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_rt_used = used;
    id_wen = wen; id_dest = d; id_long = lng;
    wb_data = $urandom; lu_data = $urandom; lu_done = extra_done;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin lu_done = 1'b1; lu_data = cur_data; end
    end
    #1;
    sw_now  = sq.size() > 0 && sq[0].due == cyc;
    e_pause = 2'b00;
    if (!r && v) begin
      e_pause[0] = rs != 0 && pend[rs];
      e_pause[1] = used && rt != 0 && pend[rt];
    end
    s_stall = (wen && pend[d]) || (lng && m_out) || (m_held && !lng);
    e_issue = !r && v && e_pause == 2'b00 && !s_stall;
    done_ok = lu_done && m_out && !m_held;
    e_we = 1'b0; e_addr = '0; e_data = '0;
    if (!r) begin
      if (sw_now) begin
        e_we = 1'b1; e_addr = sq[0].dest; e_data = wb_data;
      end else if (m_held) begin
        e_we = m_ldest != 0; e_addr = m_ldest; e_data = m_hdata;
      end else if (done_ok) begin
        e_we = m_ldest != 0; e_addr = m_ldest; e_data = lu_data;
      end
    end
    chk("pause", 32'(pause), 32'(e_pause));
    chk("issue", 32'(issue), 32'(e_issue));
    chk("lu_start", 32'(lu_start), 32'(e_issue && lng));
    chk("lu_busy", 32'(lu_busy), 32'(m_out));
    chk("rf_we", 32'(rf_we), 32'(e_we));
    if (e_we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(e_addr));
      chk("rf_wdata", rf_wdata, e_data);
    end
    if (r) begin
      foreach (pend[i]) pend[i] = 1'b0;
      sq.delete();
      m_out = 1'b0; m_held = 1'b0;
    end else begin
      was_held = m_held;
      if (sw_now) begin
        pend[sq[0].dest] = 1'b0;
        void'(sq.pop_front());
      end else if (was_held) begin
        pend[m_ldest] = 1'b0; m_held = 1'b0; m_out = 1'b0;
      end else if (done_ok) begin
        pend[m_ldest] = 1'b0; m_out = 1'b0;
      end
      if (sw_now && done_ok) begin
        m_held = 1'b1; m_hdata = lu_data;
      end
      if (e_issue) begin
        if (wen && d != 0) pend[d] = 1'b1;
        if (lng) begin
          m_out = 1'b1; m_ldest = wen ? d : 5'd0;
          cnt = next_lat; cur_data = next_data;
        end else if (wen && d != 0) begin
          sq.push_back('{cyc + SHORT_LAT, d});
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 0, 1, 3, 0, 0);
    chk("rst_pause", 32'(pause), 32'd0);
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    idle(1);
    chk("post_rst_busy", 32'(lu_busy), 32'd0);

    // Back-to-back dependency: add $3 then sub $4,$3,$5
    step(0, 1, 1, 2, 1, 1, 3, 0, 0);
    chk("add3_issue", 32'(issue), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      step(0, 1, 3, 5, 1, 1, 4, 0, 0);
      chk("dep_pause", 32'(pause), 32'b01);
      chk("dep_issue", 32'(issue), 32'd0);
      if (c == 3) begin
        chk("dep_we", 32'(rf_we), 32'd1);
        chk("dep_waddr", 32'(rf_waddr), 32'd3);
      end
    end
    step(0, 1, 3, 5, 1, 1, 4, 0, 0);
    chk("sub_issue", 32'(issue), 32'd1);
    idle(6);

    // rt gating
    step(0, 1, 0, 0, 0, 1, 6, 0, 0);
    step(0, 1, 0, 0, 0, 1, 7, 0, 0);
    step(0, 1, 0, 6, 0, 0, 0, 0, 0);
    chk("rt_unused", 32'(pause), 32'b00);
    step(0, 1, 7, 6, 1, 0, 0, 0, 0);
    chk("rs_rt_both", 32'(pause), 32'b11);
    step(0, 1, 0, 7, 1, 0, 0, 0, 0);
    chk("rt_only", 32'(pause), 32'b10);
    idle(6);

    // Collision: long $9 done in the same cycle as short write to $2
    next_lat = 4; next_data = 32'hDEADBEEF;
    step(0, 1, 0, 0, 0, 1, 9, 1, 0);
    chk("long_start", 32'(lu_start), 32'd1);
    step(0, 1, 0, 0, 0, 1, 2, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("coll_lu_done", 32'(lu_done), 32'd1);
    chk("coll_waddr", 32'(rf_waddr), 32'd2);
    step(0, 1, 0, 0, 0, 1, 10, 0, 0);
    chk("hold_stall", 32'(issue), 32'd0);
    chk("hold_waddr", 32'(rf_waddr), 32'd9);
    chk("hold_wdata", rf_wdata, 32'hDEADBEEF);
    idle(6);

    // Structural stall: second long while busy
    next_lat = 5; next_data = 32'h1234_5678;
    step(0, 1, 0, 0, 0, 1, 11, 1, 0);
    for (int c = 1; c <= 5; c++) begin
      step(0, 1, 0, 0, 0, 1, 12, 1, 0);
      chk("long_busy_stall", 32'(issue), 32'd0);
    end
    step(0, 1, 0, 0, 0, 1, 12, 1, 0);
    chk("long_after", 32'(issue), 32'd1);
    idle(8);

    // WAW stall
    step(0, 1, 0, 0, 0, 1, 13, 0, 0);
    step(0, 1, 0, 0, 0, 1, 13, 0, 0);
    chk("waw_issue", 32'(issue), 32'd0);
    chk("waw_pause", 32'(pause), 32'd0);
    idle(6);

    // $0 destination and reader
    step(0, 1, 1, 0, 0, 1, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("zero_we", 32'(rf_we), 32'd0);
    chk("zero_pause", 32'(pause), 32'd0);
    idle(4);

    // Reset with two short ops and one long op in flight
    next_lat = 6; next_data = 32'hCAFE_F00D;
    step(0, 1, 0, 0, 0, 1, 14, 1, 0);
    step(0, 1, 0, 0, 0, 1, 15, 0, 0);
    step(0, 1, 0, 0, 0, 1, 16, 0, 0);
    step(1, 1, 15, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_pause", 32'(pause), 32'd0);
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    step(0, 1, 15, 16, 1, 0, 0, 0, 0);
    chk("after_rst_busy", 32'(lu_busy), 32'd0);
    chk("after_rst_pause", 32'(pause), 32'd0);
    chk("after_rst_we", 32'(rf_we), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("stale_we", 32'(rf_we), 32'd0);
    end
    idle(4);

    // Randomized traffic over a small register window to force hazards
    for (int i = 0; i < 3000; i++) begin
      next_lat  = $urandom_range(1, 6);
      next_data = $urandom;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
           $urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)),
           $urandom_range(0, 5) == 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rf_wb_scheduler
`default_nettype wire
